// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ producers.
// A winner keeps the port for up to BURST_LEN accepted words. One IDLE
// arbitration cycle always separates two bursts. No word is ever written
// while the FIFO reports full.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 4,
    parameter int BURST_LEN = 4,
    parameter int OWN_W     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_a_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      fifo_full,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic                      busy,
    output logic [OWN_W-1:0]          owner
);

    localparam int                unsigned NREQ_U   = NUM_REQ;
    localparam int                         CNT_W    = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0]           CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [OWN_W-1:0]           OWN_LAST = OWN_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [OWN_W-1:0]   owner_q;
    logic [OWN_W-1:0]   last_owner;
    logic               busy_q;

    logic [OWN_W-1:0]   winner;
    logic               found;
    int unsigned        idx;
    logic               owner_req;
    logic               accept;
    logic [DATA_W-1:0]  owner_data;

    // Round-robin search: first requesting index above last_owner, wrapping.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 1; k <= NREQ_U; k++) begin
            idx = (32'(last_owner) + k) % NREQ_U;
            if (!found && req[idx[OWN_W-1:0]]) begin
                winner = OWN_W'(idx);
                found  = 1'b1;
            end
        end
    end

    // Select the owner's request bit and data word.
    always_comb begin
        owner_req  = 1'b0;
        owner_data = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            if (owner_q == OWN_W'(i)) begin
                owner_req  = req[i];
                owner_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Write acceptance is combinational so fifo_full blocks the write in the same cycle.
    always_comb begin
        accept         = (state == BURST) && owner_req && !fifo_full;
        grant          = '0;
        grant[owner_q] = accept;
        fifo_wr_en     = accept;
        fifo_data_in   = (state == BURST) ? owner_data : '0;
    end

    // Arbitration / burst state machine with registered busy and owner.
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            state      <= IDLE;
            count      <= '0;
            owner_q    <= '0;
            last_owner <= OWN_LAST;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state   <= BURST;
                        owner_q <= winner;
                        count   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                BURST: begin
                    if (!owner_req) begin
                        state      <= IDLE;
                        last_owner <= owner_q;
                        busy_q     <= 1'b0;
                    end else if (accept) begin
                        if (count == CNT_LAST) begin
                            state      <= IDLE;
                            last_owner <= owner_q;
                            busy_q     <= 1'b0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign owner = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: two instances (BURST_LEN 4 and 1) share the same
// stimulus and are checked every cycle against a word-counting reference
// model, plus directed scenarios with literal expected sequences.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 4;

    logic        clk = 1'b0;
    logic        rst_a_n = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] req_data = '0;
    logic        fifo_full = 1'b0;

    logic [3:0]  grant_o [2];
    logic        wr_o    [2];
    logic [3:0]  data_o  [2];
    logic        busy_o  [2];
    logic [1:0]  owner_o [2];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(4), .BURST_LEN(4)) u0 (
        .clk(clk), .rst_a_n(rst_a_n), .req(req), .req_data(req_data),
        .fifo_full(fifo_full), .grant(grant_o[0]), .fifo_wr_en(wr_o[0]),
        .fifo_data_in(data_o[0]), .busy(busy_o[0]), .owner(owner_o[0]));

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(4), .BURST_LEN(1)) u1 (
        .clk(clk), .rst_a_n(rst_a_n), .req(req), .req_data(req_data),
        .fifo_full(fifo_full), .grant(grant_o[1]), .fifo_wr_en(wr_o[1]),
        .fifo_data_in(data_o[1]), .busy(busy_o[1]), .owner(owner_o[1]));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, $signed(act), $signed(exp), $time);
        end
    endtask

    // Word written by instance b this cycle, or -1 when nothing is written.
    function automatic int wv(input int b);
        return wr_o[b] ? int'(data_o[b]) : -1;
    endfunction

    // Reference model: who owns the port and how many words it has written.
    int m_busy  [2];
    int m_owner [2];
    int m_last  [2];
    int m_words [2];
    int bl      [2] = '{4, 1};

    always @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            for (int b = 0; b < 2; b++) begin
                m_busy[b]  = 0;
                m_owner[b] = 0;
                m_last[b]  = N - 1;
                m_words[b] = 0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (m_busy[b] == 0) begin
                    if (req != 4'b0000) begin
                        int w;
                        w = -1;
                        for (int k = 1; k <= N; k++)
                            if (w < 0 && req[(m_last[b] + k) % N]) w = (m_last[b] + k) % N;
                        m_busy[b]  = 1;
                        m_owner[b] = w;
                        m_words[b] = 0;
                    end
                end else if (!req[m_owner[b]]) begin
                    m_busy[b] = 0;
                    m_last[b] = m_owner[b];
                end else if (!fifo_full) begin
                    m_words[b] = m_words[b] + 1;
                    if (m_words[b] == bl[b]) begin
                        m_busy[b] = 0;
                        m_last[b] = m_owner[b];
                    end
                end
            end
        end
    end

    // Compare both instances against the model on every falling edge.
    bit check_en = 1'b0;
    always @(negedge clk) begin
        if (check_en) begin
            for (int b = 0; b < 2; b++) begin
                logic        acc;
                logic [15:0] sh;
                logic [3:0]  eg;
                logic [3:0]  ed;
                acc = (m_busy[b] != 0) && req[m_owner[b]] && !fifo_full;
                eg  = acc ? 4'(1 << m_owner[b]) : 4'b0000;
                sh  = req_data >> (DW * m_owner[b]);
                ed  = (m_busy[b] != 0) ? sh[3:0] : 4'h0;
                chk($sformatf("grant_bl%0d", bl[b]), 32'(grant_o[b]), 32'(eg));
                chk($sformatf("wr_en_bl%0d", bl[b]), 32'(wr_o[b]), 32'(acc));
                chk($sformatf("data_bl%0d", bl[b]), 32'(data_o[b]), 32'(ed));
                chk($sformatf("busy_bl%0d", bl[b]), 32'(busy_o[b]), 32'(m_busy[b] != 0));
                chk($sformatf("owner_bl%0d", bl[b]), 32'(owner_o[b]), 32'(m_owner[b]));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        rst_a_n = 1'b0;
        next_cycle();
        rst_a_n = 1'b1;
    endtask

    int exp_order [22] = '{-1,0,0,0,0,-1,1,1,1,1,-1,2,2,2,2,-1,3,3,3,3,-1,0};
    int exp_alt   [8]  = '{-1,0,-1,3,-1,0,-1,3};
    int exp_drop  [6]  = '{-1,1,1,-1,-1,3};
    int exp_dbusy [6]  = '{0,1,1,1,0,1};

    initial begin
        int writes;
        int busy_cnt;
        req_data = {4'd3, 4'd2, 4'd1, 4'd0};
        repeat (2) @(posedge clk);
        check_en = 1'b1;
        #1;
        rst_a_n = 1'b1;

        // Idle after reset.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_grant", 32'(grant_o[0]), 32'd0);
            chk("idle_wr", 32'(wr_o[0]), 32'd0);
            chk("idle_busy", 32'(busy_o[0]), 32'd0);
            chk("idle_owner", 32'(owner_o[0]), 32'd0);
            next_cycle();
        end

        // All four requesting continuously.
        do_reset();
        req = 4'b1111;
        writes = 0;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            chk("rr_order", 32'(wv(0)), 32'(exp_order[c]));
            if (c >= 1 && c <= 20 && wr_o[0]) writes++;
            next_cycle();
        end
        chk("rr_16_of_20", 32'(writes), 32'd16);

        // BURST_LEN=1 alternation.
        do_reset();
        req = 4'b1001;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("bl1_alt", 32'(wv(1)), 32'(exp_alt[c]));
            next_cycle();
        end

        // Stall on fifo_full during burst of requester 2.
        do_reset();
        req = 4'b0100;
        writes = 0;
        busy_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            fifo_full = (c == 2 || c == 3);
            @(negedge clk);
            if (wr_o[0]) begin
                writes++;
                chk("stall_data", 32'(data_o[0]), 32'd2);
            end
            if (busy_o[0]) busy_cnt++;
            if (c == 2 || c == 3) chk("stall_grant", 32'(grant_o[0]), 32'd0);
            next_cycle();
        end
        fifo_full = 1'b0;
        chk("stall_writes", 32'(writes), 32'd4);
        chk("stall_busy", 32'(busy_cnt), 32'd6);

        // Requester 1 drops after two words; requester 3 takes over.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            req = (c < 3) ? 4'b1010 : 4'b1000;
            @(negedge clk);
            chk("drop_write", 32'(wv(0)), 32'(exp_drop[c]));
            chk("drop_busy", 32'(busy_o[0]), 32'(exp_dbusy[c]));
            next_cycle();
        end
        @(negedge clk);
        chk("drop_owner", 32'(owner_o[0]), 32'd3);
        next_cycle();

        // Reset pulse mid-burst of owner 2.
        do_reset();
        req = 4'b0100;
        repeat (3) next_cycle();
        chk("pre_rst_wr", 32'(wr_o[0]), 32'd1);
        rst_a_n = 1'b0;
        #1;
        for (int b = 0; b < 2; b++) begin
            chk("rst_grant", 32'(grant_o[b]), 32'd0);
            chk("rst_wr", 32'(wr_o[b]), 32'd0);
            chk("rst_data", 32'(data_o[b]), 32'd0);
            chk("rst_busy", 32'(busy_o[b]), 32'd0);
            chk("rst_owner", 32'(owner_o[b]), 32'd0);
        end
        next_cycle();
        rst_a_n = 1'b1;
        req = 4'b0110;
        @(negedge clk);
        chk("post_rst_idle", 32'(wv(0)), 32'hFFFF_FFFF);
        next_cycle();
        @(negedge clk);
        chk("post_rst_owner", 32'(owner_o[0]), 32'd1);
        chk("post_rst_write", 32'(wv(0)), 32'd1);
        next_cycle();

        // Randomized traffic, full flag and occasional reset pulses.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            req_data  = 16'($urandom);
            fifo_full = ($urandom_range(0, 3) == 0);
            rst_a_n   = !($urandom_range(0, 199) == 0);
            next_cycle();
        end
        rst_a_n = 1'b1;
        next_cycle();
        @(negedge clk);
        check_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
